// File: rtl/ahb_uart_tx.sv
// ahb_uart_tx
// AHB-Lite slave that queues bytes written by the core in a TX FIFO and
// serialises them onto an 8N1 UART line at a fixed HCLK divisor.
// A data write to a full FIFO stalls the bus (HREADYOUT=0) until a slot frees.
// Any read returns the status word {count, busy, empty, full}.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (frame becomes 11 bit times).

module ahb_uart_tx #(
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 434
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        TXD,
    output logic        TX_IRQ
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

`ifdef UART_TX_PARITY_EN
    // Even parity: the parity bit makes the total number of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    // Bus data-phase registers
    logic             dp_valid_r;
    logic             dp_write_r;
    logic             dp_addr2_r;

    // FIFO state
    logic [7:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_n_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             data_wr_s;

    // Shifter state
    tx_state_e        state_r;
    tx_state_e        state_n_s;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_n_s;
    logic [2:0]       bit_r;
    logic [2:0]       bit_n_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_n_s;
    logic             div_last_s;
    logic             busy_s;
    logic             txd_r;
    logic             txd_d_s;
    logic             tx_irq_r;
    logic [4:0]       cnt5_s;
    logic [31:0]      status_s;

`ifdef UART_TX_PARITY_EN
    logic [7:0]       byte_r;
`endif

    // Only HADDR[2] and HWDATA[7:0] are decoded; HSIZE is don't-care.
    logic unused_s;
    assign unused_s = ^{HSIZE, HADDR[31:3], HADDR[1:0], HWDATA[31:8]};

    // Capture the address phase whenever the bus advances; hold during stalls.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_valid_r <= 1'b0;
            dp_write_r <= 1'b0;
            dp_addr2_r <= 1'b0;
        end else if (HREADY) begin
            dp_valid_r <= HSEL & HTRANS[1];
            dp_write_r <= HWRITE;
            dp_addr2_r <= HADDR[2];
        end else begin
            dp_valid_r <= dp_valid_r;
            dp_write_r <= dp_write_r;
            dp_addr2_r <= dp_addr2_r;
        end
    end

    assign full_s     = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty_s    = (count_r == CNT_W'(0));
    assign data_wr_s  = dp_valid_r & dp_write_r & ~dp_addr2_r;
    assign push_s     = data_wr_s & ~full_s;
    assign busy_s     = (state_r != ST_IDLE);
    assign div_last_s = (div_r == DIV_W'(CLK_DIV - 1));
    assign cnt5_s     = 5'(count_r);
    assign status_s   = {19'd0, cnt5_s, 5'd0, busy_s, empty_s, full_s};

    // Stall only a data write that finds the FIFO full; everything else is zero-wait.
    assign HREADYOUT = ~(data_wr_s & full_s);

    // Read data is the live status during a read data phase, zero otherwise.
    always_comb begin
        if (dp_valid_r && !dp_write_r) begin
            HRDATA = status_s;
        end else begin
            HRDATA = 32'd0;
        end
    end

    // FIFO storage needs no reset: occupancy is tracked by count/pointers.
    always_ff @(posedge HCLK) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= HWDATA[7:0];
        end
    end

    // Next occupancy: push and pop together leave the count unchanged.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_n_s = count_r + CNT_W'(1);
            2'b01:   count_n_s = count_r - CNT_W'(1);
            default: count_n_s = count_r;
        endcase
    end

    // FIFO pointers and count; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_n_s;
        end
    end

    // Shifter next-state: bit timing, byte loading and frame sequencing.
    always_comb begin
        state_n_s = state_r;
        div_n_s   = div_r;
        bit_n_s   = bit_r;
        shift_n_s = shift_r;
        pop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s     = 1'b1;
                    shift_n_s = fifo_mem_r[rd_ptr_r];
                    div_n_s   = DIV_W'(0);
                    state_n_s = ST_START;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (div_last_s) begin
                    div_n_s   = DIV_W'(0);
                    bit_n_s   = 3'd0;
                    state_n_s = ST_DATA;
                end else begin
                    div_n_s = div_r + DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (div_last_s) begin
                    div_n_s   = DIV_W'(0);
                    shift_n_s = {1'b0, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        bit_n_s = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_n_s = ST_PARITY;
`else
                        state_n_s = ST_STOP;
`endif
                    end else begin
                        bit_n_s = bit_r + 3'd1;
                    end
                end else begin
                    div_n_s = div_r + DIV_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (div_last_s) begin
                    div_n_s   = DIV_W'(0);
                    state_n_s = ST_STOP;
                end else begin
                    div_n_s = div_r + DIV_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (div_last_s) begin
                    div_n_s = DIV_W'(0);
                    if (!empty_s) begin
                        // Back-to-back: next START follows immediately
                        pop_s     = 1'b1;
                        shift_n_s = fifo_mem_r[rd_ptr_r];
                        state_n_s = ST_START;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end else begin
                    div_n_s = div_r + DIV_W'(1);
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                div_n_s   = DIV_W'(0);
                bit_n_s   = 3'd0;
            end
        endcase
    end

    // Line level for the coming cycle, derived from next state so TXD is a flop.
    always_comb begin
        case (state_n_s)
            ST_IDLE:   txd_d_s = 1'b1;
            ST_START:  txd_d_s = 1'b0;
            ST_DATA:   txd_d_s = shift_n_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_d_s = even_parity(byte_r);
`endif
            ST_STOP:   txd_d_s = 1'b1;
            default:   txd_d_s = 1'b1;
        endcase
    end

    // Shifter registers, registered line output and registered interrupt.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r  <= ST_IDLE;
            div_r    <= '0;
            bit_r    <= 3'd0;
            shift_r  <= 8'd0;
            txd_r    <= 1'b1;
            tx_irq_r <= 1'b1;
        end else begin
            state_r  <= state_n_s;
            div_r    <= div_n_s;
            bit_r    <= bit_n_s;
            shift_r  <= shift_n_s;
            txd_r    <= txd_d_s;
            tx_irq_r <= (count_n_s == CNT_W'(0)) && (state_n_s == ST_IDLE);
        end
    end

`ifdef UART_TX_PARITY_EN
    // Keep an intact copy of the frame's byte for the parity bit.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            byte_r <= 8'd0;
        end else if (pop_s) begin
            byte_r <= fifo_mem_r[rd_ptr_r];
        end else begin
            byte_r <= byte_r;
        end
    end
`endif

    assign TXD    = txd_r;
    assign TX_IRQ = tx_irq_r;

endmodule
